cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates the single common data bus (CDB) among the processor's execution units (ALU, branch unit, LSQ load path). Each unit hands a finished result to a one-entry holding slot. Every cycle the arbiter grants the oldest held result by ROB age and broadcasts it on a registered CDB that feeds the PRF write port, the ROB completion logic and the issue-queue wakeup. On a branch mispredict, held or in-flight results younger than the branch are discarded.

## Interface
Parameters:
- NUM_REQ, 3: number of requesting execution units; index 0 is the ALU, 1 the branch unit, 2 the LSQ.
- ROB_TAG_W, 4: ROB tag width; ROB depth is 2^ROB_TAG_W.
- PREG_W, 7: physical register index width.
- DATA_W, 32: result width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- req_valid, input, NUM_REQ: per-unit result valid.
- req_ready, output, NUM_REQ: per-unit slot can accept a result this cycle.
- req_rob_tag, input, NUM_REQ×ROB_TAG_W: ROB tag of each result.
- req_has_dest, input, NUM_REQ: result writes a physical register.
- req_preg, input, NUM_REQ×PREG_W: destination physical register.
- req_data, input, NUM_REQ×DATA_W: result value.
- rob_head, input, ROB_TAG_W: tag of the current oldest ROB entry; the age reference.
- mispredict, input, 1: branch mispredict flush pulse.
- mispredict_rob_tag, input, ROB_TAG_W: ROB tag of the mispredicting branch.
- cdb_valid, output, 1: broadcast valid.
- cdb_rob_tag, output, ROB_TAG_W: broadcast ROB tag.
- cdb_we, output, 1: PRF write enable (cdb_valid & has_dest).
- cdb_preg, output, PREG_W: broadcast destination register.
- cdb_data, output, DATA_W: broadcast value.
- cdb_src, output, clog2(NUM_REQ): index of the granted unit (debug/perf).

## Operation
- State:
  - Per unit: one holding slot {hold_valid, tag, has_dest, preg, data}.
  - One CDB output register.
- Age:
  - age(t) = (t − rob_head) mod 2^ROB_TAG_W, computed unsigned in ROB_TAG_W bits. A smaller age means an older result.
  - Wrap-around is handled only by this subtraction; raw tags are never compared directly.
- Ready:
  - req_ready[i] = !hold_valid[i] | grant[i].
  - It depends only on registered state, never on req_valid, so there is no combinational path from request to ready.
- Accept: when req_valid[i] & req_ready[i] at an edge, the slot loads the payload.
- Grant (combinational):
  - Among valid slots, pick the one with minimum age.
  - Equal age cannot occur legally; if it does, the lowest index wins.
  - At most one grant per cycle.
- Broadcast:
  - At the edge, the winner's payload loads into the CDB register with cdb_valid=1.
  - The winner's slot clears unless it is simultaneously refilled.
  - If no slot is valid, cdb_valid=0 and the payload holds its last value.
- Mispredict (cycle where mispredict=1):
  - Compute kill(t) = age(t) > age(mispredict_rob_tag).
  - At the edge, clear every slot whose tag is killed.
  - Block loading of a killed incoming request; ready is still reported, so the unit drops the result.
  - Block loading of a killed winner into the CDB register; it is suppressed and cdb_valid=0 unless an older winner exists. Grant is computed over non-killed slots only.
  - The branch's own result (age equal) survives.
- Progress: the ROB head result is always the oldest, so oldest-first guarantees forward progress with no starvation.

## Timing
- Reset: all hold_valid=0; cdb_valid=0, cdb_we=0, cdb_rob_tag=0, cdb_preg=0, cdb_data=0, cdb_src=0; req_ready all 1 in the first cycle after reset.
- Latency:
  - A result accepted at edge k with no older competitor appears on the CDB after edge k+1.
  - This is 2 edges from req_valid sampling to broadcast.
- Throughput: one broadcast per cycle. A continuously granted unit sustains one result per cycle (ready stays high through simultaneous grant and refill).
- A losing unit sees req_ready=0 and must hold its payload stable until accepted.
- The CDB register holds a value for exactly one cycle; there is no backpressure from consumers.
- Reset asserted mid-operation empties all slots at that edge, with no broadcast in the following cycle.

## Test plan
- Single ALU result: tag 3, preg 40, data 0x0000_0005, rob_head 0. cdb_valid=1 with those values exactly 2 edges after acceptance; cdb_we=1; cdb_src=0.
- Contention: rob_head 14; the ALU holds tag 1 and the LSQ holds tag 15 in the same cycle. The LSQ (age 1) broadcasts first, the ALU (age 3) next cycle. ALU req_ready is 0 during the first cycle.
- Mispredict kill: rob_head 0; the branch holds tag 5 and the ALU holds tag 7; assert mispredict with tag 5. The ALU slot clears, the branch tag 5 still broadcasts, and tag 7 never appears on the CDB.
- Kill of an incoming request: mispredict tag 2 while the LSQ presents tag 4 with rob_head 0. It is accepted (ready=1) but never broadcast, and the next cycle shows cdb_valid=0.
- Back-to-back streaming: the ALU presents tags 0,1,2,3 on consecutive cycles and nothing else is active. req_ready stays 1 and the CDB shows tags 0..3 on 4 consecutive cycles.
- No-dest result: a branch with has_dest=0 gives cdb_valid=1 and cdb_we=0.
- Reset mid-stream: all three slots are full and reset is asserted for one cycle. The next cycle shows cdb_valid=0 with all req_ready=1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bundle of the execution-unit request side, the age/flush inputs and the
// registered common data bus broadcast of the CDB arbiter.
// master: the execution-unit / ROB side; slave: the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int ROB_TAG_W = 4,
    parameter int PREG_W    = 7,
    parameter int DATA_W    = 32
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // per-unit result handoff
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][ROB_TAG_W-1:0]  req_rob_tag;
    logic [NUM_REQ-1:0]                 req_has_dest;
    logic [NUM_REQ-1:0][PREG_W-1:0]     req_preg;
    logic [NUM_REQ-1:0][DATA_W-1:0]     req_data;

    // age reference and branch flush
    logic [ROB_TAG_W-1:0]               rob_head;
    logic                               mispredict;
    logic [ROB_TAG_W-1:0]               mispredict_rob_tag;

    // registered broadcast
    logic                               cdb_valid;
    logic [ROB_TAG_W-1:0]               cdb_rob_tag;
    logic                               cdb_we;
    logic [PREG_W-1:0]                  cdb_preg;
    logic [DATA_W-1:0]                  cdb_data;
    logic [SRC_W-1:0]                   cdb_src;

    modport master (
        output req_valid, req_rob_tag, req_has_dest, req_preg, req_data,
        output rob_head, mispredict, mispredict_rob_tag,
        input  req_ready,
        input  cdb_valid, cdb_rob_tag, cdb_we, cdb_preg, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_rob_tag, req_has_dest, req_preg, req_data,
        input  rob_head, mispredict, mispredict_rob_tag,
        output req_ready,
        output cdb_valid, cdb_rob_tag, cdb_we, cdb_preg, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, oldest-first
// (by ROB age relative to rob_head) grant, registered broadcast, and discard
// of results younger than a mispredicting branch.
module cdb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ROB_TAG_W = 4,
    parameter int PREG_W    = 7,
    parameter int DATA_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Ages wrap naturally through the ROB_TAG_W-bit subtraction; raw tags are
    // never compared against each other.
    function automatic logic [ROB_TAG_W-1:0] age_of(
        input logic [ROB_TAG_W-1:0] tag,
        input logic [ROB_TAG_W-1:0] head
    );
        return tag - head;
    endfunction

    logic [NUM_REQ-1:0]                 hold_valid;
    logic [NUM_REQ-1:0]                 hold_has_dest;
    logic [NUM_REQ-1:0][ROB_TAG_W-1:0]  hold_tag;
    logic [NUM_REQ-1:0][PREG_W-1:0]     hold_preg;
    logic [NUM_REQ-1:0][DATA_W-1:0]     hold_data;

    logic [ROB_TAG_W-1:0]               br_age;
    logic [NUM_REQ-1:0][ROB_TAG_W-1:0]  hold_age;
    logic [NUM_REQ-1:0][ROB_TAG_W-1:0]  in_age;
    logic [NUM_REQ-1:0]                 kill_slot;
    logic [NUM_REQ-1:0]                 kill_in;

    logic                               win_found;
    logic [SRC_W-1:0]                   win_idx;
    logic [ROB_TAG_W-1:0]               win_age;
    logic [ROB_TAG_W-1:0]               win_tag;
    logic                               win_has_dest;
    logic [PREG_W-1:0]                  win_preg;
    logic [DATA_W-1:0]                  win_data;
    logic [NUM_REQ-1:0]                 grant;

    logic [NUM_REQ-1:0]                 accept;
    logic [NUM_REQ-1:0]                 load;

    logic                               cdb_valid_q;
    logic [ROB_TAG_W-1:0]               cdb_tag_q;
    logic                               cdb_we_q;
    logic [PREG_W-1:0]                  cdb_preg_q;
    logic [DATA_W-1:0]                  cdb_data_q;
    logic [SRC_W-1:0]                   cdb_src_q;

    // Ages of held and incoming results, and which of them a mispredict kills.
    // The branch itself (equal age) is never killed.
    always_comb begin
        br_age    = age_of(bus.mispredict_rob_tag, bus.rob_head);
        hold_age  = '0;
        in_age    = '0;
        kill_slot = '0;
        kill_in   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_age[i]  = age_of(hold_tag[i], bus.rob_head);
            in_age[i]    = age_of(bus.req_rob_tag[i], bus.rob_head);
            kill_slot[i] = bus.mispredict & hold_valid[i] & (hold_age[i] > br_age);
            kill_in[i]   = bus.mispredict & (in_age[i] > br_age);
        end
    end

    // Oldest surviving slot wins; strict compare keeps the lowest index on a tie.
    always_comb begin
        win_found    = 1'b0;
        win_idx      = '0;
        win_age      = '0;
        win_tag      = '0;
        win_has_dest = 1'b0;
        win_preg     = '0;
        win_data     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hold_valid[i] && !kill_slot[i] &&
                (!win_found || (hold_age[i] < win_age))) begin
                win_found    = 1'b1;
                win_idx      = SRC_W'(i);
                win_age      = hold_age[i];
                win_tag      = hold_tag[i];
                win_has_dest = hold_has_dest[i];
                win_preg     = hold_preg[i];
                win_data     = hold_data[i];
            end
        end
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = win_found && (win_idx == SRC_W'(i));
        end
    end

    // Ready comes only from slot state and the grant, never from req_valid.
    // A killed incoming result is still acknowledged so the unit drops it.
    assign bus.req_ready = ~hold_valid | grant;
    assign accept        = bus.req_valid & bus.req_ready;
    assign load          = accept & ~kill_in;

    // Slot occupancy: refill wins over the clear from a grant, so a granted
    // unit streams one result per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (load[i]) begin
                    hold_valid[i] <= 1'b1;
                end else if (grant[i] || kill_slot[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload is qualified by hold_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
                hold_tag[i]      <= bus.req_rob_tag[i];
                hold_has_dest[i] <= bus.req_has_dest[i];
                hold_preg[i]     <= bus.req_preg[i];
                hold_data[i]     <= bus.req_data[i];
            end
        end
    end

    // Registered broadcast: valid for exactly one cycle per grant; payload
    // holds its last value when idle, write enable drops with valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_we_q    <= 1'b0;
            cdb_preg_q  <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else if (win_found) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= win_tag;
            cdb_we_q    <= win_has_dest;
            cdb_preg_q  <= win_preg;
            cdb_data_q  <= win_data;
            cdb_src_q   <= win_idx;
        end else begin
            cdb_valid_q <= 1'b0;
            cdb_we_q    <= 1'b0;
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_tag = cdb_tag_q;
    assign bus.cdb_we      = cdb_we_q;
    assign bus.cdb_preg    = cdb_preg_q;
    assign bus.cdb_data    = cdb_data_q;
    assign bus.cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scenario tasks drive the units and
// check ready/valid timing inline; a scoreboard queue holds the broadcasts
// each scenario expects and the negedge monitor compares them in order.
module tb_cdb_arbiter;
    localparam int NUM_REQ   = 3;
    localparam int ROB_TAG_W = 4;
    localparam int PREG_W    = 7;
    localparam int DATA_W    = 32;

    typedef struct {
        logic [ROB_TAG_W-1:0] tag;
        logic                 we;
        logic [PREG_W-1:0]    preg;
        logic [DATA_W-1:0]    data;
        logic [1:0]           src;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_TAG_W(ROB_TAG_W),
                     .PREG_W(PREG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_TAG_W(ROB_TAG_W),
                  .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // scoreboard monitor: every broadcast must match the next expected entry
    always @(negedge clk) begin
        exp_t e;
        if (bus.cdb_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL cdb_unexpected: got tag=%0d src=%0d data=%h, required no broadcast",
                         bus.cdb_rob_tag, bus.cdb_src, bus.cdb_data);
            end else begin
                e = sb.pop_front();
                if (bus.cdb_rob_tag !== e.tag || bus.cdb_we !== e.we ||
                    bus.cdb_preg !== e.preg || bus.cdb_data !== e.data ||
                    bus.cdb_src !== e.src) begin
                    n_fail++;
                    $display("FAIL cdb_payload: got tag=%0d we=%0b preg=%0d data=%h src=%0d, required tag=%0d we=%0b preg=%0d data=%h src=%0d",
                             bus.cdb_rob_tag, bus.cdb_we, bus.cdb_preg, bus.cdb_data, bus.cdb_src,
                             e.tag, e.we, e.preg, e.data, e.src);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ROB_TAG_W-1:0] tag,
                           input logic has_dest, input logic [PREG_W-1:0] preg,
                           input logic [DATA_W-1:0] data);
        bus.req_valid[i]    = 1'b1;
        bus.req_rob_tag[i]  = tag;
        bus.req_has_dest[i] = has_dest;
        bus.req_preg[i]     = preg;
        bus.req_data[i]     = data;
    endtask

    task automatic clr_reqs();
        bus.req_valid = '0;
    endtask

    task automatic push_exp(input logic [ROB_TAG_W-1:0] tag, input logic we,
                            input logic [PREG_W-1:0] preg, input logic [DATA_W-1:0] data,
                            input logic [1:0] src);
        exp_t e;
        e.tag = tag; e.we = we; e.preg = preg; e.data = data; e.src = src;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '0; bus.req_rob_tag = '0; bus.req_has_dest = '0;
        bus.req_preg = '0; bus.req_data = '0;
        bus.rob_head = '0; bus.mispredict = 1'b0; bus.mispredict_rob_tag = '0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got valid=%0b we=%0b, required 0 0", bus.cdb_valid, bus.cdb_we);
        end
        n_checks++;
        if (bus.cdb_rob_tag !== '0 || bus.cdb_preg !== '0 || bus.cdb_data !== '0 || bus.cdb_src !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got tag=%0d preg=%0d data=%h src=%0d, required all 0",
                     bus.cdb_rob_tag, bus.cdb_preg, bus.cdb_data, bus.cdb_src);
        end
        n_checks++;
        if (bus.req_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 111", bus.req_ready);
        end
    endtask

    task automatic test_single();
        bus.rob_head = 4'd0;
        set_req(0, 4'd3, 1'b1, 7'd40, 32'h0000_0005);
        push_exp(4'd3, 1'b1, 7'd40, 32'h0000_0005, 2'd0);
        n_checks++;
        if (bus.req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b, required 1", bus.req_ready[0]);
        end
        tick();
        clr_reqs();
        n_checks++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got valid=%0b one edge after accept, required 0", bus.cdb_valid);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_we !== 1'b1 || bus.cdb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%0b we=%0b src=%0d, required 1 1 0",
                     bus.cdb_valid, bus.cdb_we, bus.cdb_src);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: got valid=%0b, required 0", bus.cdb_valid);
        end
    endtask

    task automatic test_contention();
        bus.rob_head = 4'd14;
        set_req(0, 4'd1,  1'b1, 7'd10, 32'h0000_00AA);
        set_req(2, 4'd15, 1'b1, 7'd20, 32'h0000_00BB);
        push_exp(4'd15, 1'b1, 7'd20, 32'h0000_00BB, 2'd2);
        push_exp(4'd1,  1'b1, 7'd10, 32'h0000_00AA, 2'd0);
        tick();
        clr_reqs();
        n_checks++;
        if (bus.req_ready !== 3'b110) begin
            n_fail++;
            $display("FAIL contention_ready: got %b, required 110", bus.req_ready);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2) begin
            n_fail++;
            $display("FAIL contention_first: got valid=%0b src=%0d, required 1 2", bus.cdb_valid, bus.cdb_src);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL contention_second: got valid=%0b src=%0d, required 1 0", bus.cdb_valid, bus.cdb_src);
        end
        tick();
    endtask

    task automatic test_mispredict_kill();
        bus.rob_head = 4'd0;
        set_req(1, 4'd5, 1'b1, 7'd12, 32'h0000_0055);
        set_req(0, 4'd7, 1'b1, 7'd17, 32'h0000_0077);
        tick();
        clr_reqs();
        bus.mispredict = 1'b1;
        bus.mispredict_rob_tag = 4'd5;
        push_exp(4'd5, 1'b1, 7'd12, 32'h0000_0055, 2'd1);
        n_checks++;
        if (bus.req_ready !== 3'b110) begin
            n_fail++;
            $display("FAIL kill_ready_during: got %b, required 110", bus.req_ready);
        end
        tick();
        bus.mispredict = 1'b0;
        n_checks++;
        if (bus.req_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL kill_slot_cleared: got ready %b, required 111", bus.req_ready);
        end
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL kill_branch_survives: got valid=%0b tag=%0d, required 1 5", bus.cdb_valid, bus.cdb_rob_tag);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_younger_gone: got valid=%0b tag=%0d, required valid 0", bus.cdb_valid, bus.cdb_rob_tag);
        end
    endtask

    task automatic test_kill_incoming();
        bus.rob_head = 4'd0;
        bus.mispredict = 1'b1;
        bus.mispredict_rob_tag = 4'd2;
        set_req(2, 4'd4, 1'b1, 7'd50, 32'hDEAD_BEEF);
        n_checks++;
        if (bus.req_ready[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_in_ready: got %b, required 1", bus.req_ready[2]);
        end
        tick();
        clr_reqs();
        bus.mispredict = 1'b0;
        n_checks++;
        if (bus.req_ready !== 3'b111 || bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_in_dropped: got ready=%b valid=%0b, required 111 0", bus.req_ready, bus.cdb_valid);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_in_no_bcast: got valid=%0b, required 0", bus.cdb_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.rob_head = 4'd0;
        for (int i = 0; i < 4; i++) begin
            set_req(0, ROB_TAG_W'(i), 1'b1, PREG_W'(60 + i), DATA_W'(32'h100 + i));
            push_exp(ROB_TAG_W'(i), 1'b1, PREG_W'(60 + i), DATA_W'(32'h100 + i), 2'd0);
            n_checks++;
            if (bus.req_ready[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready: beat %0d got %b, required 1", i, bus.req_ready[0]);
            end
            tick();
            if (i >= 1) begin
                n_checks++;
                if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== ROB_TAG_W'(i - 1)) begin
                    n_fail++;
                    $display("FAIL stream_bcast: got valid=%0b tag=%0d, required 1 %0d",
                             bus.cdb_valid, bus.cdb_rob_tag, i - 1);
                end
            end
        end
        clr_reqs();
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== 4'd3) begin
            n_fail++;
            $display("FAIL stream_last: got valid=%0b tag=%0d, required 1 3", bus.cdb_valid, bus.cdb_rob_tag);
        end
        tick();
    endtask

    task automatic test_no_dest();
        bus.rob_head = 4'd0;
        set_req(1, 4'd9, 1'b0, 7'd3, 32'h0000_0123);
        push_exp(4'd9, 1'b0, 7'd3, 32'h0000_0123, 2'd1);
        tick();
        clr_reqs();
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL no_dest: got valid=%0b we=%0b, required 1 0", bus.cdb_valid, bus.cdb_we);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.rob_head = 4'd0;
        set_req(0, 4'd0, 1'b1, 7'd1, 32'h0000_0A00);
        set_req(1, 4'd1, 1'b1, 7'd2, 32'h0000_0B00);
        set_req(2, 4'd2, 1'b1, 7'd3, 32'h0000_0C00);
        tick();
        clr_reqs();
        reset = 1'b1;
        n_checks++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL rstmid_full: got ready %b, required 001", bus.req_ready);
        end
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_we !== 1'b0 || bus.req_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL rstmid_after: got valid=%0b we=%0b ready=%b, required 0 0 111",
                     bus.cdb_valid, bus.cdb_we, bus.req_ready);
        end
        tick();
        n_checks++;
        if (bus.cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_empty: got valid=%0b, required 0", bus.cdb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_mispredict_kill();
        test_kill_incoming();
        test_back_to_back();
        test_no_dest();
        test_reset_mid();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending broadcasts, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
